// File: rtl/max_pool_sequencer.sv
// rtl/max_pool_sequencer.sv - column sequencer driving a pooling datapath across tiles
module max_pool_sequencer #(
  parameter int SA_LENGTH       = 256,
  parameter int MAX_FILTER_SIZE = 7,
  parameter int ADDR_WIDTH      = 16,
  parameter int TILE_WIDTH      = 8
) (
  input  logic                                 CLK,
  input  logic                                 ASYNC_RST,
  input  logic                                 Start,
  input  logic                                 Abort,
  input  logic [$clog2(SA_LENGTH)-1:0]         ImageWidth,
  input  logic [$clog2(MAX_FILTER_SIZE+1)-1:0] FilterSize,
  input  logic [TILE_WIDTH-1:0]                NumTiles,
  input  logic [ADDR_WIDTH-1:0]                SrcBase,
  input  logic [ADDR_WIDTH-1:0]                DstBase,
  output logic                                 Busy,
  output logic                                 Done,
  output logic                                 Error,
  output logic                                 RdEn,
  output logic [ADDR_WIDTH-1:0]                RdAddr,
  output logic                                 PoolEn,
  output logic                                 PoolSyncRst,
  output logic [$clog2(SA_LENGTH)-1:0]         PoolWidth,
  output logic [$clog2(MAX_FILTER_SIZE+1)-1:0] PoolFilter,
  output logic                                 WrEn,
  output logic [ADDR_WIDTH-1:0]                WrAddr
);

  localparam int WW = $clog2(SA_LENGTH);
  localparam int FW = $clog2(MAX_FILTER_SIZE + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [WW-1:0]           width_q, width_d;
  logic [FW-1:0]           filter_q, filter_d;
  logic [TILE_WIDTH-1:0]   tiles_q, tiles_d;
  logic [TILE_WIDTH-1:0]   tile_idx_q, tile_idx_d;
  logic [ADDR_WIDTH-1:0]   rdptr_q, rdptr_d;
  logic [ADDR_WIDTH-1:0]   wrptr_q, wrptr_d;
  logic [WW-1:0]           col_q, col_d;
  logic [FW-1:0]           win_q, win_d;
  logic                    drain_q, drain_d;
  logic                    win_done_q, win_done_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic                    rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic                    pool_en_q, pool_en_d;
  logic                    pool_sync_rst_q, pool_sync_rst_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic                    cfg_ok;
  logic                    col_last;
  logic                    win_last;

  assign cfg_ok = (FilterSize >= FW'(2)) && (FilterSize <= FW'(MAX_FILTER_SIZE)) &&
                  (ImageWidth != '0) && ({{(WW-FW){1'b0}}, FilterSize} <= ImageWidth) &&
                  (NumTiles != '0);
  assign col_last = (col_q == width_q - WW'(1));
  assign win_last = (win_q == filter_q - FW'(1));

  // Next-state, counters and next-cycle output values; outputs are registered from these
  always_comb begin
    state_d         = state_q;
    width_d         = width_q;
    filter_d        = filter_q;
    tiles_d         = tiles_q;
    tile_idx_d      = tile_idx_q;
    rdptr_d         = rdptr_q;
    wrptr_d         = wrptr_q;
    col_d           = col_q;
    win_d           = win_q;
    drain_d         = drain_q;
    win_done_d      = 1'b0;
    done_d          = 1'b0;
    error_d         = 1'b0;
    rd_en_d         = 1'b0;
    rd_addr_d       = rd_addr_q;
    pool_en_d       = 1'b0;
    pool_sync_rst_d = 1'b0;
    wr_en_d         = 1'b0;
    wr_addr_d       = wr_addr_q;

    // A column finishing a window in its PoolEn cycle is written one cycle later
    if (pool_en_q && win_done_q) begin
      wr_en_d   = 1'b1;
      wr_addr_d = wrptr_q;
      wrptr_d   = wrptr_q + ADDR_WIDTH'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (Start && !Abort) begin
          width_d    = ImageWidth;
          filter_d   = FilterSize;
          tiles_d    = NumTiles;
          rdptr_d    = SrcBase;
          wrptr_d    = DstBase;
          tile_idx_d = '0;
          if (cfg_ok) state_d = S_CLEAR;
          else        error_d = 1'b1;
        end
      end
      S_CLEAR: begin
        col_d   = '0;
        win_d   = '0;
        drain_d = 1'b0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        pool_en_d  = 1'b1;
        win_done_d = col_last || win_last;
        win_d      = (col_last || win_last) ? '0 : win_q + FW'(1);
        col_d      = col_q + WW'(1);
        if (col_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        drain_d = ~drain_q;
        if (drain_q) begin
          if (tile_idx_q == tiles_q - TILE_WIDTH'(1)) begin
            state_d = S_DONE;
          end else begin
            tile_idx_d = tile_idx_q + TILE_WIDTH'(1);
            state_d    = S_CLEAR;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort drops everything in flight and resets the datapath
    if (busy_q && Abort) begin
      state_d         = S_IDLE;
      pool_en_d       = 1'b0;
      win_done_d      = 1'b0;
      wr_en_d         = 1'b0;
      wr_addr_d       = wr_addr_q;
      pool_sync_rst_d = 1'b1;
    end

    if (state_d == S_STREAM) begin
      rd_en_d   = 1'b1;
      rd_addr_d = rdptr_q;
      rdptr_d   = rdptr_q + ADDR_WIDTH'(1);
    end
    if (state_d == S_CLEAR) pool_sync_rst_d = 1'b1;
    busy_d = (state_d == S_CLEAR) || (state_d == S_STREAM) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  // State, counters and registered outputs
  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      state_q         <= S_IDLE;
      width_q         <= '0;
      filter_q        <= '0;
      tiles_q         <= '0;
      tile_idx_q      <= '0;
      rdptr_q         <= '0;
      wrptr_q         <= '0;
      col_q           <= '0;
      win_q           <= '0;
      drain_q         <= 1'b0;
      win_done_q      <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
      rd_en_q         <= 1'b0;
      rd_addr_q       <= '0;
      pool_en_q       <= 1'b0;
      pool_sync_rst_q <= 1'b0;
      wr_en_q         <= 1'b0;
      wr_addr_q       <= '0;
    end else begin
      state_q         <= state_d;
      width_q         <= width_d;
      filter_q        <= filter_d;
      tiles_q         <= tiles_d;
      tile_idx_q      <= tile_idx_d;
      rdptr_q         <= rdptr_d;
      wrptr_q         <= wrptr_d;
      col_q           <= col_d;
      win_q           <= win_d;
      drain_q         <= drain_d;
      win_done_q      <= win_done_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      error_q         <= error_d;
      rd_en_q         <= rd_en_d;
      rd_addr_q       <= rd_addr_d;
      pool_en_q       <= pool_en_d;
      pool_sync_rst_q <= pool_sync_rst_d;
      wr_en_q         <= wr_en_d;
      wr_addr_q       <= wr_addr_d;
    end
  end

  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Error       = error_q;
  assign RdEn        = rd_en_q;
  assign RdAddr      = rd_addr_q;
  assign PoolEn      = pool_en_q;
  assign PoolSyncRst = pool_sync_rst_q;
  assign PoolWidth   = width_q;
  assign PoolFilter  = filter_q;
  assign WrEn        = wr_en_q;
  assign WrAddr      = wr_addr_q;

endmodule

// File: tb/tb_max_pool_sequencer.sv
// tb/tb_max_pool_sequencer.sv - directed bench for max_pool_sequencer
module tb_max_pool_sequencer;

  logic        CLK = 1'b0;
  logic        ASYNC_RST = 1'b0;
  logic        Start = 1'b0;
  logic        Abort = 1'b0;
  logic [7:0]  ImageWidth = '0;
  logic [2:0]  FilterSize = '0;
  logic [7:0]  NumTiles = '0;
  logic [15:0] SrcBase = '0;
  logic [15:0] DstBase = '0;
  logic        Busy, Done, Error, RdEn, PoolEn, PoolSyncRst, WrEn;
  logic [15:0] RdAddr, WrAddr;
  logic [7:0]  PoolWidth;
  logic [2:0]  PoolFilter;

  int errors = 0;
  int checks = 0;

  max_pool_sequencer dut (
    .CLK(CLK), .ASYNC_RST(ASYNC_RST), .Start(Start), .Abort(Abort),
    .ImageWidth(ImageWidth), .FilterSize(FilterSize), .NumTiles(NumTiles),
    .SrcBase(SrcBase), .DstBase(DstBase), .Busy(Busy), .Done(Done), .Error(Error),
    .RdEn(RdEn), .RdAddr(RdAddr), .PoolEn(PoolEn), .PoolSyncRst(PoolSyncRst),
    .PoolWidth(PoolWidth), .PoolFilter(PoolFilter), .WrEn(WrEn), .WrAddr(WrAddr)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        err;
    logic        rd;
    logic [15:0] rda;
    logic        pool;
    logic        sync;
    logic        wr;
    logic [15:0] wra;
  } obs_t;

  typedef struct {
    string       name;
    int          w;
    int          f;
    int          t;
    logic [15:0] src;
    logic [15:0] dst;
    int          exp_done;
    int          exp_nwr;
  } vec_t;

  function automatic obs_t sample();
    obs_t o;
    o = {Busy, Done, Error, RdEn, RdAddr, PoolEn, PoolSyncRst, WrEn, WrAddr};
    return o;
  endfunction

  // Expected outputs in cycle n, taken from the documented per-tile timetable
  function automatic obs_t model(int n, int w, int f, int t, logic [15:0] src,
                                 logic [15:0] dst, logic valid, int abort_cyc);
    obs_t e;
    int tl, tile, r, k, opt;
    e = '0;
    if (abort_cyc == 0) return e;
    if (!valid) begin
      e.err = (n == 1);
      return e;
    end
    if (abort_cyc > 0 && n > abort_cyc) begin
      e.sync = (n == abort_cyc + 1);
      return e;
    end
    tl = w + 3;
    if (n >= 1 && n <= t * tl) begin
      tile   = (n - 1) / tl;
      r      = n - 1 - tile * tl;
      e.busy = 1'b1;
      e.sync = (r == 0);
      if (r >= 1 && r <= w) begin
        e.rd  = 1'b1;
        e.rda = src + 16'(tile * w + r - 1);
      end
      e.pool = (r >= 2 && r <= w + 1);
      if (r >= 3) begin
        k   = r - 3;
        opt = (w + f - 1) / f;
        if ((k % f) == f - 1 || k == w - 1) begin
          e.wr  = 1'b1;
          e.wra = dst + 16'(tile * opt + k / f);
        end
      end
    end
    e.done = (n == 1 + t * tl);
    return e;
  endfunction

  task automatic run_job(input string name, input int w, input int f, input int t,
                         input logic [15:0] src, input logic [15:0] dst,
                         input int abort_cyc, input int extra_start_cyc, input int ncyc,
                         output int done_cyc, output int nwr);
    obs_t a, e;
    logic valid;
    valid = (f >= 2) && (f <= 7) && (w >= 1) && (f <= w) && (t >= 1);
    done_cyc = -1;
    nwr = 0;
    @(posedge CLK); #1;
    ImageWidth = 8'(w);
    FilterSize = 3'(f);
    NumTiles   = 8'(t);
    SrcBase    = src;
    DstBase    = dst;
    Start      = 1'b1;
    Abort      = (abort_cyc == 0);
    for (int n = 0; n < ncyc; n++) begin
      if (n > 0) begin
        @(posedge CLK); #1;
        Start = (n == extra_start_cyc);
        Abort = (n == abort_cyc);
        if (n == extra_start_cyc) begin
          ImageWidth = 8'd3;
          FilterSize = 3'd3;
          NumTiles   = 8'd1;
          SrcBase    = 16'h5555;
        end
      end
      @(negedge CLK);
      a = sample();
      e = model(n, w, f, t, src, dst, valid, abort_cyc);
      if (!e.rd) a.rda = '0;
      if (!e.wr) a.wra = '0;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h want %h", name, n, a, e);
      end
      if (Done) done_cyc = n;
      if (WrEn) nwr++;
    end
    Start = 1'b0;
    Abort = 1'b0;
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  vec_t vecs[8];
  int   dc, nw, ncyc;

  initial begin
    vecs[0] = '{"w8f2t1",   8, 2, 1, 16'h0010, 16'h0040, 12, 4};
    vecs[1] = '{"w7f3t1",   7, 3, 1, 16'h0020, 16'h0080, 11, 3};
    vecs[2] = '{"w4f2t3",   4, 2, 3, 16'h0000, 16'h0100, 22, 6};
    vecs[3] = '{"w2f2t1",   2, 2, 1, 16'h0300, 16'h0400,  6, 1};
    vecs[4] = '{"bad_f1",   4, 1, 1, 16'h0000, 16'h0000, -1, 0};
    vecs[5] = '{"bad_f5w4", 4, 5, 1, 16'h0000, 16'h0000, -1, 0};
    vecs[6] = '{"bad_t0",   4, 2, 0, 16'h0000, 16'h0000, -1, 0};
    vecs[7] = '{"w8f7wrap", 8, 7, 2, 16'hFFFC, 16'hFFFF, 23, 4};

    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (sample() !== '0 || PoolWidth !== '0 || PoolFilter !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", sample());
    end
    ASYNC_RST = 1'b1;

    for (int i = 0; i < 8; i++) begin
      ncyc = (vecs[i].exp_done < 0) ? 6 : vecs[i].exp_done + 3;
      run_job(vecs[i].name, vecs[i].w, vecs[i].f, vecs[i].t, vecs[i].src, vecs[i].dst,
              -1, -1, ncyc, dc, nw);
      check_int({vecs[i].name, "_done_cycle"}, dc, vecs[i].exp_done);
      check_int({vecs[i].name, "_writes"}, nw, vecs[i].exp_nwr);
      if (vecs[i].exp_done > 0) begin
        check_int({vecs[i].name, "_pool_width"}, int'(PoolWidth), vecs[i].w);
        check_int({vecs[i].name, "_pool_filter"}, int'(PoolFilter), vecs[i].f);
      end
    end

    run_job("abort_c5", 8, 2, 1, 16'h0010, 16'h0040, 5, -1, 16, dc, nw);
    check_int("abort_no_done", dc, -1);
    check_int("abort_writes", nw, 1);

    run_job("start_while_busy", 4, 2, 1, 16'h0700, 16'h0800, -1, 3, 11, dc, nw);
    check_int("start_while_busy_done", dc, 8);
    check_int("start_while_busy_writes", nw, 2);

    run_job("abort_and_start", 4, 2, 1, 16'h0000, 16'h0000, 0, -1, 6, dc, nw);
    check_int("abort_and_start_done", dc, -1);
    check_int("abort_and_start_writes", nw, 0);

    run_job("reset_prefix", 8, 2, 1, 16'h0010, 16'h0040, -1, -1, 5, dc, nw);
    ASYNC_RST = 1'b0;
    #1;
    checks++;
    if (sample() !== '0 || PoolWidth !== '0 || PoolFilter !== '0) begin
      errors++;
      $display("FAIL midjob_reset: got %h want 0", sample());
    end
    @(posedge CLK); #1;
    ASYNC_RST = 1'b1;
    run_job("after_reset", 8, 2, 1, 16'h0010, 16'h0040, -1, -1, 15, dc, nw);
    check_int("after_reset_done", dc, 12);
    check_int("after_reset_writes", nw, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/max_pool_sequencer.md
# max_pool_sequencer

Controller that drives one pooling datapath instance through one or more feature-map tiles stored column-by-column in the input buffer, and writes the pooled columns to the output buffer. It latches a pooling job on `Start` and validates the configuration. It then issues column reads, drives the datapath's `EN` and `SYNC_RST`, and generates output-buffer write strobes aligned to the datapath's registered output. It sits between the layer-level control FSM and the pooling datapath / column SRAMs.

## Interface
- `SA_LENGTH`, 256: lanes per column; also the maximum image width.
- `MAX_FILTER_SIZE`, 7: largest legal pooling window.
- `ADDR_WIDTH`, 16: column address width for both buffers.
- `TILE_WIDTH`, 8: width of the tile-count field.
- `CLK`  in  1  clock.
- `ASYNC_RST`  in  1  reset, asynchronous, active-low.
- `Start`  in  1  job request; sampled only in IDLE.
- `Abort`  in  1  synchronous job cancel.
- `ImageWidth`  in  $clog2(SA_LENGTH)  columns per tile (W).
- `FilterSize`  in  $clog2(MAX_FILTER_SIZE+1)  window size (F).
- `NumTiles`  in  TILE_WIDTH  tiles in the job (T).
- `SrcBase`  in  ADDR_WIDTH  first input column address.
- `DstBase`  in  ADDR_WIDTH  first output column address.
- `Busy`  out  1  high from CLEAR through the final DRAIN.
- `Done`  out  1  one-cycle pulse on job completion.
- `Error`  out  1  one-cycle pulse when a configuration is rejected.
- `RdEn`  out  1  input buffer read strobe; read data arrives 1 cycle later.
- `RdAddr`  out  ADDR_WIDTH  input column address.
- `PoolEn`  out  1  datapath `EN`.
- `PoolSyncRst`  out  1  datapath `SYNC_RST`.
- `PoolWidth`  out  $clog2(SA_LENGTH)  latched W, to the datapath.
- `PoolFilter`  out  $clog2(MAX_FILTER_SIZE+1)  latched F, to the datapath.
- `WrEn`  out  1  output buffer write strobe; buffer captures datapath `OutputColumn`.
- `WrAddr`  out  ADDR_WIDTH  output column address.

## Operation
- States: IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE:
  - On `Start`, latch W, F, T, `SrcBase` and `DstBase`.
  - A configuration is valid iff 2 ≤ F ≤ MAX_FILTER_SIZE, 1 ≤ W, F ≤ W, and T ≥ 1.
  - Valid configuration: go to CLEAR.
  - Invalid configuration: pulse `Error` next cycle and stay in IDLE.
- CLEAR (1 cycle): `PoolSyncRst`=1. Column counter k=0, window counter f=0, output index o=0.
- STREAM (W cycles):
  - `RdEn`=1 and `RdAddr`=rdptr each cycle; rdptr increments.
  - After the last column, go to DRAIN.
- Pipeline, one stage behind each read:
  - `PoolEn`=1 in the cycle the read data is valid.
  - That column completes a window if f==F-1 or k==W-1.
  - On window completion: f wraps to 0, and a `WrEn` is scheduled for the next cycle with `WrAddr`=wrptr; wrptr and o then increment.
- DRAIN (2 cycles): finishes the last `PoolEn` and `WrEn`.
  - Then go to CLEAR if tiles remain; rdptr and wrptr continue contiguously.
  - Otherwise go to DONE.
- DONE (1 cycle): `Done`=1, then IDLE.
- Outputs per tile = ceil(W/F); the final partial window is written.
- Address arithmetic wraps modulo 2^ADDR_WIDTH; no overflow flag.
- `Start` while `Busy` is ignored.
- `Abort` while `Busy`:
  - Next cycle: `PoolSyncRst`=1, state IDLE.
  - All scheduled `PoolEn`/`WrEn` are suppressed; no `Done`.
  - `Abort` and `Start` in the same IDLE cycle: `Abort` wins, no job starts.
- Reset values: all outputs 0, state IDLE, all counters and pointers 0.
- Reset mid-job: immediate return to these values.

## Timing
- `Start` accepted at cycle 0; the tile starts at cycle c=1.
- Per-tile schedule:
  - CLEAR at c.
  - Read of column k at c+1+k.
  - `PoolEn` for column k at c+2+k.
  - `WrEn` for a window ending at column k at c+3+k.
- Tile length W+3 cycles; the next tile's CLEAR immediately follows DRAIN.
- `Done` at cycle 1+T·(W+3).
- `Busy` high during cycles 1 .. T·(W+3).
- `Error` is asserted in cycle 1 and `Busy` stays 0.
- All outputs are registered; `RdEn`, `PoolEn` and `WrEn` are never high in CLEAR.

## Test plan
- W=8, F=2, T=1, SrcBase=0x10, DstBase=0x40:
  - Reads at cycles 2–9, addresses 0x10–0x17.
  - `WrEn` at cycles 5, 7, 9, 11, addresses 0x40–0x43.
  - `Done` at cycle 12.
- W=7, F=3, T=1:
  - `WrEn` at cycles 6, 9, 10, writing 3 columns.
  - Written data equals the per-lane max of columns {0–2}, {3–5}, {6}.
- W=4, F=2, T=3, SrcBase=0, DstBase=0x100:
  - `PoolSyncRst` at cycles 1, 8, 15.
  - Reads at 0–11 contiguous; writes at 0x100–0x105.
  - `Done` at cycle 22.
- Invalid starts (F=1; F=5 with W=4; T=0):
  - Each gives `Error` at cycle 1.
  - `Busy`, `RdEn` and `WrEn` stay 0; a subsequent valid `Start` runs normally.
- `Abort` at cycle 5 of a W=8 job:
  - Cycle 6: `PoolSyncRst`=1, state IDLE.
  - No `WrEn` after cycle 5, no `Done`.
  - `Start` during `Busy` has no effect.
- `ASYNC_RST` low at cycle 4 of a job: all outputs 0 immediately; after release, IDLE and a new job completes correctly.
